// File: rtl/range_arb_pkg.sv
// Shared definitions for the range session arbiter: session states and
// the default sizing constants used by the top level.
package range_arb_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_CNTW  = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FIRST,
    STREAM,
    FIN_ONE,
    RESULT,
    REPORT
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: searches the request vector starting one position
// above the previous owner and returns a one-hot grant plus its index.
module rr_arbiter
  import range_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
)(
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_last,
  output logic [NREQ-1:0] o_grant,
  output logic [PW-1:0]   o_grantIdx,
  output logic            o_any
);

  // Walk the requesters in rotated order and keep the first one found
  always_comb begin
    int w_idx;
    w_idx      = 0;
    o_grant    = '0;
    o_grantIdx = '0;
    o_any      = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = (int'(i_last) + k) % NREQ;
      if (!o_any && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        o_grantIdx     = PW'(w_idx);
        o_any          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/range_session_arbiter.sv
// Grants one requester at a time a session with the shared range finder,
// forwards the owner's samples to it and reports the resulting range,
// sticky error and sample count back to the owner.
module range_session_arbiter
  import range_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ,
  parameter int CNTW  = DEF_CNTW
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       s_valid,
  input  logic [NREQ-1:0]       s_last,
  input  logic [NREQ*WIDTH-1:0] s_data,
  output logic [NREQ-1:0]       s_ready,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      range_out,
  output logic                  err_out,
  output logic [CNTW-1:0]       count_out,
  output logic [WIDTH-1:0]      rf_data,
  output logic                  rf_go,
  output logic                  rf_finish,
  input  logic [WIDTH-1:0]      rf_range,
  input  logic                  rf_error
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            r_state;
  logic [NREQ-1:0]   r_grant;
  logic [NREQ-1:0]   r_done;
  logic [PW-1:0]     r_owner;
  logic [PW-1:0]     r_last;
  logic [CNTW-1:0]   r_count;
  logic              r_err;
  logic [WIDTH-1:0]  r_rfData;
  logic              r_rfGo;
  logic              r_rfFinish;
  logic [WIDTH-1:0]  r_rangeOut;
  logic              r_errOut;
  logic [CNTW-1:0]   r_countOut;

  logic [NREQ-1:0]   w_rrGrant;
  logic [PW-1:0]     w_rrIdx;
  logic              w_anyReq;
  logic              w_accept;
  logic              w_last;
  logic [WIDTH-1:0]  w_sample;
  logic [CNTW-1:0]   w_countNext;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .i_req      (req),
    .i_last     (r_last),
    .o_grant    (w_rrGrant),
    .o_grantIdx (w_rrIdx),
    .o_any      (w_anyReq)
  );

  // Only the owner is offered ready, and only while samples are expected
  assign s_ready     = (r_state == WAIT_FIRST || r_state == STREAM) ? r_grant : '0;
  assign w_accept    = |(s_valid & s_ready);
  assign w_last      = s_last[r_owner];
  assign w_sample    = s_data[r_owner*WIDTH +: WIDTH];
  assign w_countNext = (&r_count) ? r_count : r_count + CNTW'(1);

  assign grant     = r_grant;
  assign done      = r_done;
  assign rf_data   = r_rfData;
  assign rf_go     = r_rfGo;
  assign rf_finish = r_rfFinish;
  assign range_out = r_rangeOut;
  assign err_out   = r_errOut;
  assign count_out = r_countOut;

  // Session FSM; strobes default low each cycle so go/finish/done are single pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_done     <= '0;
      r_owner    <= '0;
      r_last     <= PW'(NREQ - 1);
      r_count    <= '0;
      r_err      <= 1'b0;
      r_rfData   <= '0;
      r_rfGo     <= 1'b0;
      r_rfFinish <= 1'b0;
      r_rangeOut <= '0;
      r_errOut   <= 1'b0;
      r_countOut <= '0;
    end else begin
      r_rfGo     <= 1'b0;
      r_rfFinish <= 1'b0;
      r_done     <= '0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_grant <= w_rrGrant;
            r_owner <= w_rrIdx;
            r_count <= '0;
            r_err   <= 1'b0;
            r_state <= WAIT_FIRST;
          end
        end
        WAIT_FIRST: begin
          if (w_accept) begin
            r_rfGo   <= 1'b1;
            r_rfData <= w_sample;
            r_count  <= w_countNext;
            r_state  <= w_last ? FIN_ONE : STREAM;
          end
        end
        STREAM: begin
          r_err <= r_err | rf_error;
          if (w_accept) begin
            r_rfData   <= w_sample;
            r_rfFinish <= w_last;
            r_count    <= w_countNext;
            if (w_last) r_state <= RESULT;
          end
        end
        FIN_ONE: begin
          r_err      <= r_err | rf_error;
          r_rfFinish <= 1'b1;
          r_state    <= RESULT;
        end
        RESULT: begin
          if (r_rfFinish) begin
            r_err <= r_err | rf_error;
          end else begin
            r_rangeOut <= rf_range;
            r_errOut   <= r_err | rf_error;
            r_countOut <= r_count;
            r_done     <= r_grant;
            r_state    <= REPORT;
          end
        end
        REPORT: begin
          r_grant <= '0;
          r_last  <= r_owner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_session_arbiter.sv
// Directed bench for range_session_arbiter with a behavioural range finder
// (max minus min of every sample presented from rf_go through rf_finish).
module tb_range_session_arbiter;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int CNTW  = 16;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req, s_valid, s_last, s_ready, grant, done;
  logic [NREQ*WIDTH-1:0] s_data;
  logic [WIDTH-1:0]      range_out, rf_data, rf_range;
  logic                  err_out, rf_go, rf_finish, rf_error;
  logic [CNTW-1:0]       count_out;

  int checks = 0;
  int errors = 0;
  int goTotal = 0;
  int ovlViol = 0;
  int ohViol = 0;
  int spViol = 0;
  int sinceFin = 100;
  logic [NREQ-1:0] reqHold = '0;

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  expGrant;
    logic [3:0]  expReady;
    logic [3:0]  expDone;
    logic        expGo;
    logic        expFin;
    logic [7:0]  expData;
    logic [7:0]  expRange;
    logic [15:0] expCount;
    logic        expErr;
  } vec_t;

  vec_t vecs [15];

  always #5 clock = ~clock;

  range_session_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .grant     (grant),
    .done      (done),
    .range_out (range_out),
    .err_out   (err_out),
    .count_out (count_out),
    .rf_data   (rf_data),
    .rf_go     (rf_go),
    .rf_finish (rf_finish),
    .rf_range  (rf_range),
    .rf_error  (rf_error)
  );

  // Range finder model: tracks min/max of the presented samples
  logic [7:0] mMin, mMax;
  logic       mActive;
  always @(posedge clock) begin
    if (reset) begin
      mActive <= 1'b0;
      mMin    <= '0;
      mMax    <= '0;
    end else if (rf_go) begin
      mMin    <= rf_data;
      mMax    <= rf_data;
      mActive <= 1'b1;
    end else if (mActive) begin
      if (rf_data < mMin) mMin <= rf_data;
      if (rf_data > mMax) mMax <= rf_data;
      if (rf_finish) mActive <= 1'b0;
    end
  end
  assign rf_range = mMax - mMin;

  // Protocol monitor: go/finish overlap, grant one-hot, finish-to-go spacing
  always @(negedge clock) begin
    if (!reset) begin
      if (rf_go && rf_finish) ovlViol++;
      if ((grant & (grant - 4'd1)) != 0) ohViol++;
      if (rf_go) begin
        goTotal++;
        if (sinceFin < 3) spViol++;
      end
      if (rf_finish) sinceFin = 0;
      else if (sinceFin < 100) sinceFin++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req     = v.req;
    s_valid = v.valid;
    s_last  = v.last;
    s_data  = v.data;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic runSession(input int owner, input int n, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input int gap, input int errAt,
                            input logic [7:0] expRange, input logic expErr);
    logic [7:0] smp [3];
    logic [3:0] bitMask;
    int goStart;
    int waitN;
    smp[0] = s0; smp[1] = s1; smp[2] = s2;
    bitMask = 4'(1 << owner);
    req = reqHold | bitMask;
    waitN = 0;
    while (grant == 0 && waitN < 30) begin step(); waitN++; end
    checkOutput("grantOrder", grant, bitMask);
    goStart = goTotal;
    for (int k = 0; k < n; k++) begin
      s_valid  = bitMask;
      s_last   = (k == n - 1) ? bitMask : 4'h0;
      s_data   = '0;
      s_data[owner*8 +: 8] = smp[k];
      rf_error = (k == errAt);
      waitN = 0;
      while ((s_ready & bitMask) == 0 && waitN < 30) begin step(); waitN++; end
      checkOutput("readyWait", s_ready & bitMask, bitMask);
      step();
      s_valid  = '0;
      s_last   = '0;
      rf_error = 1'b0;
      req      = reqHold;
      checkOutput("rfData", rf_data, smp[k]);
      if (k < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          step();
          checkOutput("rfHold", rf_data, smp[k]);
        end
      end
    end
    waitN = 0;
    while (done == 0 && waitN < 30) begin step(); waitN++; end
    checkOutput("done", done, bitMask);
    checkOutput("rangeOut", range_out, expRange);
    checkOutput("countOut", count_out, n);
    checkOutput("errOut", err_out, expErr);
    checkOutput("goOnce", goTotal - goStart, 1);
    step();
    checkOutput("doneClr", done, 0);
    checkOutput("grantClr", grant, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic doneSeen;
    int waitN;
    //             req   val   last  data          grnt  rdy   done  go    fin   rfData rng    cnt     err
    vecs[0]  = '{4'h1, 4'h0, 4'h0, 32'h00000000, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd0,  8'd0, 16'd0, 1'b0};
    vecs[1]  = '{4'h1, 4'h1, 4'h0, 32'h0000000A, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 8'd0,  8'd0, 16'd0, 1'b0};
    vecs[2]  = '{4'h1, 4'h1, 4'h0, 32'h00000003, 4'h1, 4'h1, 4'h0, 1'b1, 1'b0, 8'd10, 8'd0, 16'd0, 1'b0};
    vecs[3]  = '{4'h1, 4'h1, 4'h1, 32'h00000007, 4'h1, 4'h1, 4'h0, 1'b0, 1'b0, 8'd3,  8'd0, 16'd0, 1'b0};
    vecs[4]  = '{4'h0, 4'h0, 4'h0, 32'h00000000, 4'h1, 4'h0, 4'h0, 1'b0, 1'b1, 8'd7,  8'd0, 16'd0, 1'b0};
    vecs[5]  = '{4'h0, 4'h0, 4'h0, 32'h00000000, 4'h1, 4'h0, 4'h0, 1'b0, 1'b0, 8'd7,  8'd0, 16'd0, 1'b0};
    vecs[6]  = '{4'h0, 4'h0, 4'h0, 32'h00000000, 4'h1, 4'h0, 4'h1, 1'b0, 1'b0, 8'd7,  8'd7, 16'd3, 1'b0};
    vecs[7]  = '{4'h0, 4'h0, 4'h0, 32'h00000000, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd7,  8'd7, 16'd3, 1'b0};
    vecs[8]  = '{4'h4, 4'h0, 4'h0, 32'h00000000, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd7,  8'd7, 16'd3, 1'b0};
    vecs[9]  = '{4'h4, 4'h5, 4'h5, 32'h002A0063, 4'h4, 4'h4, 4'h0, 1'b0, 1'b0, 8'd7,  8'd7, 16'd3, 1'b0};
    vecs[10] = '{4'h0, 4'h0, 4'h0, 32'h00000000, 4'h4, 4'h0, 4'h0, 1'b1, 1'b0, 8'd42, 8'd7, 16'd3, 1'b0};
    vecs[11] = '{4'h0, 4'h0, 4'h0, 32'h00000000, 4'h4, 4'h0, 4'h0, 1'b0, 1'b1, 8'd42, 8'd7, 16'd3, 1'b0};
    vecs[12] = '{4'h0, 4'h0, 4'h0, 32'h00000000, 4'h4, 4'h0, 4'h0, 1'b0, 1'b0, 8'd42, 8'd7, 16'd3, 1'b0};
    vecs[13] = '{4'h0, 4'h0, 4'h0, 32'h00000000, 4'h4, 4'h0, 4'h4, 1'b0, 1'b0, 8'd42, 8'd0, 16'd1, 1'b0};
    vecs[14] = '{4'h0, 4'h0, 4'h0, 32'h00000000, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd42, 8'd0, 16'd1, 1'b0};

    reset = 1'b1; req = '0; s_valid = '0; s_last = '0; s_data = '0; rf_error = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("rstGrant", grant, 0);
    checkOutput("rstReady", s_ready, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstGoFin", {rf_go, rf_finish}, 0);
    checkOutput("rstData", rf_data, 0);
    checkOutput("rstResult", {err_out, range_out, count_out}, 0);
    reset = 1'b0;

    // Requester 0 stream 10,3,7 then requester 2 single sample 42 with non-owner noise
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_grant", i), grant, vecs[i].expGrant);
      checkOutput($sformatf("v%0d_ready", i), s_ready, vecs[i].expReady);
      checkOutput($sformatf("v%0d_done", i), done, vecs[i].expDone);
      checkOutput($sformatf("v%0d_go", i), rf_go, vecs[i].expGo);
      checkOutput($sformatf("v%0d_fin", i), rf_finish, vecs[i].expFin);
      checkOutput($sformatf("v%0d_rfData", i), rf_data, vecs[i].expData);
      checkOutput($sformatf("v%0d_range", i), range_out, vecs[i].expRange);
      checkOutput($sformatf("v%0d_count", i), count_out, vecs[i].expCount);
      checkOutput($sformatf("v%0d_err", i), err_out, vecs[i].expErr);
      @(negedge clock);
    end
    applyStimulus('0);

    // Round robin: owner 1, then req1+req3 -> 3 then 1
    runSession(1, 1, 8'd20, 8'd0, 8'd0, 0, -1, 8'd0, 1'b0);
    reqHold = 4'b0010;
    runSession(3, 2, 8'd30, 8'd35, 8'd0, 0, -1, 8'd5, 1'b0);
    reqHold = 4'b0000;
    runSession(1, 1, 8'd50, 8'd0, 8'd0, 0, -1, 8'd0, 1'b0);

    // Valid gaps of two cycles between 5 and 9
    runSession(0, 2, 8'd5, 8'd9, 8'd0, 2, -1, 8'd4, 1'b0);

    // One-cycle rf_error pulse mid-session
    runSession(2, 3, 8'd1, 8'd2, 8'd3, 0, 1, 8'd2, 1'b1);

    // Reset while streaming aborts without a done pulse
    req = 4'h1;
    waitN = 0;
    while (grant == 0 && waitN < 30) begin step(); waitN++; end
    s_valid = 4'h1; s_data = 32'h0000000B;
    step();
    s_data = 32'h0000000C;
    step();
    checkOutput("preRstData", rf_data, 8'd12);
    s_valid = '0;
    reset = 1'b1;
    step();
    checkOutput("midRstGrant", grant, 0);
    checkOutput("midRstReady", s_ready, 0);
    checkOutput("midRstDone", done, 0);
    checkOutput("midRstGoFin", {rf_go, rf_finish}, 0);
    checkOutput("midRstData", rf_data, 0);
    checkOutput("midRstResult", {err_out, range_out, count_out}, 0);
    reset = 1'b0;
    req = '0;
    doneSeen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      doneSeen = doneSeen | (|done);
    end
    checkOutput("noDoneAfterRst", doneSeen, 0);
    req = 4'hF;
    step();
    checkOutput("rstPriority", grant, 4'h1);
    req = '0;

    checkOutput("goFinOverlap", ovlViol, 0);
    checkOutput("grantOneHot", ohViol, 0);
    checkOutput("finToGoSpacing", spViol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
